// File: rtl/muldiv_pkg.sv
// muldiv_pkg: state/op types, alucontrol codes and decode for the HI/LO unit.
// MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU to the decoder.
package muldiv_pkg;

    localparam int DIV_ITER_DEF = 32;

    localparam logic [7:0] MULT_CONTROL  = 8'h18;
    localparam logic [7:0] MULTU_CONTROL = 8'h19;
    localparam logic [7:0] DIV_CONTROL   = 8'h1A;
    localparam logic [7:0] DIVU_CONTROL  = 8'h1B;
    localparam logic [7:0] MADD_CONTROL  = 8'h1C;
    localparam logic [7:0] MADDU_CONTROL = 8'h1D;
    localparam logic [7:0] MSUB_CONTROL  = 8'h1E;
    localparam logic [7:0] MSUBU_CONTROL = 8'h1F;
    localparam logic [7:0] MTHI_CONTROL  = 8'h11;
    localparam logic [7:0] MTLO_CONTROL  = 8'h13;

    typedef enum logic [1:0] {
        IDLE, MUL, DIV, DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL, OP_DIV, OP_MADD, OP_MSUB
    } op_kind_e;

    typedef struct packed {
        op_kind_e kind;
        logic     sgn;
    } op_t;

    typedef struct packed {
        logic valid;
        op_t  op;
    } dec_t;

    // Only multi-cycle ops decode as valid; MTHI/MTLO are handled apart.
    function automatic dec_t decode(input logic [7:0] ctl);
        dec_t d;
        d.valid = 1'b1;
        d.op    = '{kind: OP_MUL, sgn: 1'b0};
        case (ctl)
            MULT_CONTROL:  d.op = '{kind: OP_MUL, sgn: 1'b1};
            MULTU_CONTROL: d.op = '{kind: OP_MUL, sgn: 1'b0};
            DIV_CONTROL:   d.op = '{kind: OP_DIV, sgn: 1'b1};
            DIVU_CONTROL:  d.op = '{kind: OP_DIV, sgn: 1'b0};
`ifdef MULDIV_MADD_EN
            MADD_CONTROL:  d.op = '{kind: OP_MADD, sgn: 1'b1};
            MADDU_CONTROL: d.op = '{kind: OP_MADD, sgn: 1'b0};
            MSUB_CONTROL:  d.op = '{kind: OP_MSUB, sgn: 1'b1};
            MSUBU_CONTROL: d.op = '{kind: OP_MSUB, sgn: 1'b0};
`endif
            default:       d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage bundle between the pipeline and muldiv_ctrl.
// master = pipeline (drives op/operands/flush/stall_in); slave = unit.
interface muldiv_if;
    logic        e_valid;
    logic [7:0]  alucontrol;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_in;
    logic        stall_e;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output e_valid, alucontrol, src_a, src_b, flush, stall_in,
        input  stall_e, hi, lo, busy
    );

    modport slave (
        input  e_valid, alucontrol, src_a, src_b, flush, stall_in,
        output stall_e, hi, lo, busy
    );
endinterface

// File: rtl/muldiv_div_radix2.sv
// div_radix2: 32-bit unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, rst, start, abort, dividend, divisor -> done, quotient, remainder.
module div_radix2 #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int CW = $clog2(ITER + 1);

    logic [31:0]   quo_q, quo_d;
    logic [31:0]   rem_q, rem_d;
    logic [31:0]   dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic [32:0]   trial;
    logic [32:0]   diff;

    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        trial = {rem_q, quo_q[31]};
        diff  = trial - {1'b0, dvs_q};
        // high while the final bit is being produced this cycle
        done  = run_q && (cnt_q == '0);
        if (abort) begin
            quo_d = '0;
            rem_d = '0;
            dvs_d = '0;
            cnt_d = '0;
            run_d = 1'b0;
        end else if (start) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
            cnt_d = CW'(ITER - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            // borrow out of bit 32 means trial < divisor: restore
            if (!diff[32]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: MULT/DIV sequencer and HI/LO owner beside the E-stage ALU.
// Ports: clk, rst, bus (muldiv_if.slave). MULDIV_MADD_EN enables MADD/MSUB.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = DIV_ITER_DEF
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int MX = (DIV_ITER > MUL_LAT) ? DIV_ITER : MUL_LAT;
    localparam int CW = $clog2(MX + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    op_t           op_q, op_d;
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;
    logic          dz_q, dz_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [63:0]   mul_q [MUL_LAT];
    logic [63:0]   mul_d [MUL_LAT];

    dec_t        dec;
    logic        go, sgn, last;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] a_mag, b_mag;
    logic        div_start, div_done;
    logic [31:0] div_quo, div_rem;
    logic [31:0] quo_fix, rem_fix;
    logic [63:0] res;

    always_comb begin
        dec   = decode(bus.alucontrol);
        go    = bus.e_valid & ~bus.flush & (state_q == IDLE) & dec.valid;
        sgn   = dec.op.sgn;
        // sign-extend then take low 64 bits: one multiplier for both
        ext_a = {{32{sgn & bus.src_a[31]}}, bus.src_a};
        ext_b = {{32{sgn & bus.src_b[31]}}, bus.src_b};
        prod  = ext_a * ext_b;
        a_mag = (sgn & bus.src_a[31]) ? -bus.src_a : bus.src_a;
        b_mag = (sgn & bus.src_b[31]) ? -bus.src_b : bus.src_b;
        div_start = go & (dec.op.kind == OP_DIV) & (bus.src_b != '0);
    end

    div_radix2 #(.ITER(DIV_ITER)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (bus.flush),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        quo_fix = q_neg_q ? -div_quo : div_quo;
        rem_fix = r_neg_q ? -div_rem : div_rem;
        case (op_q.kind)
            OP_DIV:  res = dz_q ? {a_q, 32'hFFFF_FFFF}
                                : {rem_fix, quo_fix};
`ifdef MULDIV_MADD_EN
            OP_MADD: res = {hi_q, lo_q} + mul_q[MUL_LAT-1];
            OP_MSUB: res = {hi_q, lo_q} - mul_q[MUL_LAT-1];
`endif
            default: res = mul_q[MUL_LAT-1];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        a_d         = a_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        bus.stall_e = 1'b0;
        mul_d[0]    = go ? prod : mul_q[0];
        for (int i = 1; i < MUL_LAT; i++) mul_d[i] = mul_q[i-1];
        last = (state_q == DIV) ? div_done : (cnt_q == '0);

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    bus.stall_e = 1'b1;
                    op_d    = dec.op;
                    a_d     = bus.src_a;
                    q_neg_d = sgn & (bus.src_a[31] ^ bus.src_b[31]);
                    r_neg_d = sgn & bus.src_a[31];
                    dz_d    = 1'b0;
                    if (dec.op.kind == OP_DIV) begin
                        if (bus.src_b == '0) begin
                            dz_d    = 1'b1;
                            state_d = DONE;
                        end else begin
                            cnt_d   = CW'(DIV_ITER - 1);
                            state_d = DIV;
                        end
                    end else begin
                        cnt_d   = CW'(MUL_LAT - 1);
                        state_d = MUL;
                    end
                end else if (bus.e_valid & ~bus.flush & ~bus.stall_in) begin
                    if (bus.alucontrol == MTHI_CONTROL) hi_d = bus.src_a;
                    if (bus.alucontrol == MTLO_CONTROL) lo_d = bus.src_a;
                end
            end
            MUL, DIV: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    bus.stall_e = 1'b1;
                    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                    if (last) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (!bus.stall_in) begin
                    {hi_d, lo_d} = res;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '{kind: OP_MUL, sgn: 1'b0};
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            for (int i = 0; i < MUL_LAT; i++) mul_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            for (int i = 0; i < MUL_LAT; i++) mul_q[i] <= mul_d[i];
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: vector table, corner sequences and random ops vs a model.
// Also exercises MADD/MSUB when built with MULDIV_MADD_EN.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_LAT  = 2;
    localparam int DIV_ITER = 32;
    localparam int ST_MUL   = MUL_LAT + 1;
    localparam int ST_DIV   = DIV_ITER + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        int          st;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        tbl [12];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference: architectural effect of one op on HI/LO, plus stall count.
    task automatic model(input logic [7:0] c, input logic [31:0] a,
                         input logic [31:0] b, output int st);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        st = 0;
        case (c)
            MULT_CONTROL: begin
                {m_hi, m_lo} = 64'(sa * sb);
                st = ST_MUL;
            end
            MULTU_CONTROL: begin
                {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
                st = ST_MUL;
            end
            DIV_CONTROL, DIVU_CONTROL: begin
                if (b == 0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                    st = 1;
                end else if (c == DIV_CONTROL) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                    st = ST_DIV;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                    st = ST_DIV;
                end
            end
            MTHI_CONTROL: m_hi = a;
            MTLO_CONTROL: m_lo = a;
`ifdef MULDIV_MADD_EN
            MADD_CONTROL: begin
                {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb);
                st = ST_MUL;
            end
            MADDU_CONTROL: begin
                {m_hi, m_lo} = {m_hi, m_lo} + {32'b0, a} * {32'b0, b};
                st = ST_MUL;
            end
            MSUB_CONTROL: begin
                {m_hi, m_lo} = {m_hi, m_lo} - 64'(sa * sb);
                st = ST_MUL;
            end
            MSUBU_CONTROL: begin
                {m_hi, m_lo} = {m_hi, m_lo} - {32'b0, a} * {32'b0, b};
                st = ST_MUL;
            end
`endif
            default: ;
        endcase
    endtask

    // Hold the op in E while stall_e is high, then retire it.
    task automatic run_op(input logic [7:0] c, input logic [31:0] a,
                          input logic [31:0] b, output int st);
        @(negedge clk);
        bus.e_valid    = 1'b1;
        bus.alucontrol = c;
        bus.src_a      = a;
        bus.src_b      = b;
        st = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!bus.stall_e) break;
            st++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.e_valid = 1'b0;
    endtask

    initial begin
        int st, est;
        logic [7:0]  c;
        logic [31:0] a, b, hold_hi, hold_lo;

        tbl[0]  = '{MULT_CONTROL,  32'hFFFF_FFFF, 32'd2, ST_MUL,
                    32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[1]  = '{MULTU_CONTROL, 32'hFFFF_FFFF, 32'd2, ST_MUL,
                    32'h1, 32'hFFFF_FFFE};
        tbl[2]  = '{DIVU_CONTROL, 32'd100, 32'd7, ST_DIV, 32'd2, 32'd14};
        tbl[3]  = '{DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, ST_DIV,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4]  = '{DIV_CONTROL, 32'd7, 32'hFFFF_FFFE, ST_DIV,
                    32'd1, 32'hFFFF_FFFD};
        tbl[5]  = '{MULT_CONTROL, 32'h8000_0000, 32'h8000_0000, ST_MUL,
                    32'h4000_0000, 32'h0};
        tbl[6]  = '{DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, ST_DIV,
                    32'h0, 32'h8000_0000};
        tbl[7]  = '{DIV_CONTROL, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF};
        tbl[8]  = '{MTHI_CONTROL, 32'hCAFE, 32'd0, 0,
                    32'hCAFE, 32'hFFFF_FFFF};
        tbl[9]  = '{MTLO_CONTROL, 32'hBEEF, 32'd0, 0, 32'hCAFE, 32'hBEEF};
        tbl[10] = '{8'hFF, 32'h1234, 32'h5, 0, 32'hCAFE, 32'hBEEF};
        tbl[11] = '{DIVU_CONTROL, 32'hFFFF_FFFF, 32'd1, ST_DIV,
                    32'h0, 32'hFFFF_FFFF};

        bus.e_valid    = 1'b0;
        bus.alucontrol = '0;
        bus.src_a      = '0;
        bus.src_b      = '0;
        bus.flush      = 1'b0;
        bus.stall_in   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall_e", 64'(bus.stall_e), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].ctl, tbl[i].a, tbl[i].b, st);
            check($sformatf("tbl%0d_stall", i), 64'(st), 64'(tbl[i].st));
            check($sformatf("tbl%0d_hi", i), 64'(bus.hi), 64'(tbl[i].hi));
            check($sformatf("tbl%0d_lo", i), 64'(bus.lo), 64'(tbl[i].lo));
            check($sformatf("tbl%0d_busy", i), 64'(bus.busy), 64'(0));
        end
        m_hi = tbl[11].hi;
        m_lo = tbl[11].lo;

        // flush at divider iteration 10
        @(negedge clk);
        bus.e_valid    = 1'b1;
        bus.alucontrol = DIVU_CONTROL;
        bus.src_a      = 32'd1000;
        bus.src_b      = 32'd3;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_busy_pre", 64'(bus.busy), 64'(1));
        check("flush_stall_e", 64'(bus.stall_e), 64'(0));
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.e_valid = 1'b0;
        #1;
        check("flush_busy", 64'(bus.busy), 64'(0));
        check("flush_stall_e_after", 64'(bus.stall_e), 64'(0));
        check("flush_hi", 64'(bus.hi), 64'(m_hi));
        check("flush_lo", 64'(bus.lo), 64'(m_lo));

        // flush blocks go in IDLE
        @(negedge clk);
        bus.e_valid    = 1'b1;
        bus.alucontrol = MULT_CONTROL;
        bus.flush      = 1'b1;
        #1;
        check("flush_go_stall", 64'(bus.stall_e), 64'(0));
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.e_valid = 1'b0;
        check("flush_go_busy", 64'(bus.busy), 64'(0));

        // flush in DONE beats the commit
        @(negedge clk);
        bus.e_valid    = 1'b1;
        bus.alucontrol = MULTU_CONTROL;
        bus.src_a      = 32'd9;
        bus.src_b      = 32'd9;
        repeat (ST_MUL) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.e_valid = 1'b0;
        check("flush_done_busy", 64'(bus.busy), 64'(0));
        check("flush_done_lo", 64'(bus.lo), 64'(m_lo));

        // DONE held by stall_in for 3 cycles
        run_op(MTHI_CONTROL, 32'h55, 32'd0, st);
        run_op(MTLO_CONTROL, 32'd0, 32'd0, st);
        @(negedge clk);
        bus.e_valid    = 1'b1;
        bus.alucontrol = MULTU_CONTROL;
        bus.src_a      = 32'd6;
        bus.src_b      = 32'd7;
        repeat (ST_MUL) @(negedge clk);
        bus.stall_in = 1'b1;
        #1;
        check("hold_stall_e", 64'(bus.stall_e), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_busy", k), 64'(bus.busy), 64'(1));
            check($sformatf("hold%0d_lo", k), 64'(bus.lo), 64'(0));
            check($sformatf("hold%0d_hi", k), 64'(bus.hi), 64'(32'h55));
        end
        @(negedge clk);
        bus.stall_in = 1'b0;
        @(posedge clk);
        #1;
        bus.e_valid = 1'b0;
        check("hold_commit_lo", 64'(bus.lo), 64'(42));
        check("hold_commit_hi", 64'(bus.hi), 64'(0));
        check("hold_commit_busy", 64'(bus.busy), 64'(0));
        @(posedge clk);
        #1;
        check("hold_no_reissue", 64'(bus.busy), 64'(0));
        m_hi = 32'h0;
        m_lo = 32'd42;

`ifdef MULDIV_MADD_EN
        run_op(MTHI_CONTROL, 32'd0, 32'd0, st);
        run_op(MTLO_CONTROL, 32'd5, 32'd0, st);
        run_op(MADDU_CONTROL, 32'd3, 32'd4, st);
        check("maddu_stall", 64'(st), 64'(ST_MUL));
        check("maddu_lo", 64'(bus.lo), 64'(17));
        check("maddu_hi", 64'(bus.hi), 64'(0));
        run_op(MSUB_CONTROL, 32'd1, 32'd20, st);
        check("msub_hi", 64'(bus.hi), 64'(32'hFFFF_FFFF));
        check("msub_lo", 64'(bus.lo), 64'(32'hFFFF_FFFD));
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFFD;
`endif

        // reset in the middle of a divide
        @(negedge clk);
        bus.e_valid    = 1'b1;
        bus.alucontrol = DIV_CONTROL;
        bus.src_a      = 32'd1000;
        bus.src_b      = 32'd7;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.e_valid = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_stall_e", 64'(bus.stall_e), 64'(0));
        check("midrst_hi", 64'(bus.hi), 64'(0));
        check("midrst_lo", 64'(bus.lo), 64'(0));
        m_hi = 32'h0;
        m_lo = 32'h0;

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 11))
                0:  c = MULT_CONTROL;
                1:  c = MULTU_CONTROL;
                2:  c = DIV_CONTROL;
                3:  c = DIVU_CONTROL;
                4:  c = MTHI_CONTROL;
                5:  c = MTLO_CONTROL;
                6:  c = MADD_CONTROL;
                7:  c = MADDU_CONTROL;
                8:  c = MSUB_CONTROL;
                9:  c = MSUBU_CONTROL;
                10: c = DIV_CONTROL;
                default: c = 8'($urandom_range(0, 255));
            endcase
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 20));
                3:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            model(c, a, b, est);
            run_op(c, a, b, st);
            check($sformatf("rnd%0d_c%0h_stall", n, c), 64'(st), 64'(est));
            check($sformatf("rnd%0d_c%0h_hi", n, c), 64'(bus.hi), 64'(m_hi));
            check($sformatf("rnd%0d_c%0h_lo", n, c), 64'(bus.lo), 64'(m_lo));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
